// File: rtl/kernel_bank_loader_pkg.sv
// rtl/kernel_bank_loader_pkg.sv - shared types and default widths for the kernel bank loader
// Purpose : FSM state encoding and default parameter values used by kernel_bank_loader
//           and its read-latency delay line.
// Ports   : none (package)
package kernel_bank_loader_pkg;

   localparam int DEF_WEIGHT_WIDTH    = 8;
   localparam int DEF_BRAM_ADDR_WIDTH = 10;
   localparam int DEF_KREG_ADDR_WIDTH = 6;
   localparam int DEF_NUM_CH          = 4;
   localparam int DEF_BRAM_RD_LAT     = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/kernel_bank_loader_rd_lat_pipe.sv
// rtl/kernel_bank_loader_rd_lat_pipe.sv - delay line carrying {valid, ch, elem} for BRAM read latency
// Purpose : delays the read tag by DEPTH cycles so it lines up with the BRAM read data.
// Ports   : i_clk, i_rst         clock, synchronous active-high reset (flushes the line)
//           i_valid/i_ch/i_elem  tag of the read issued this cycle
//           o_valid/o_ch/o_elem  tag of the read issued DEPTH cycles ago
module rd_lat_pipe
   import kernel_bank_loader_pkg::*;
#(
   parameter int DEPTH  = DEF_BRAM_RD_LAT,
   parameter int CH_W   = 2,
   parameter int ELEM_W = DEF_KREG_ADDR_WIDTH
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [CH_W-1:0]   i_ch,
   input  logic [ELEM_W-1:0] i_elem,
   output logic              o_valid,
   output logic [CH_W-1:0]   o_ch,
   output logic [ELEM_W-1:0] o_elem
);

   logic [DEPTH-1:0]  v_q;
   logic [CH_W-1:0]   ch_q [DEPTH];
   logic [ELEM_W-1:0] el_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ch_q[i] <= '0;
            el_q[i] <= '0;
         end
      end else begin
         v_q[0]  <= i_valid;
         ch_q[0] <= i_ch;
         el_q[0] <= i_elem;
         for (int i = 1; i < DEPTH; i++) begin
            v_q[i]  <= v_q[i-1];
            ch_q[i] <= ch_q[i-1];
            el_q[i] <= el_q[i-1];
         end
      end
   end

   assign o_valid = v_q[DEPTH-1];
   assign o_ch    = ch_q[DEPTH-1];
   assign o_elem  = el_q[DEPTH-1];

endmodule

// File: rtl/kernel_bank_loader.sv
// rtl/kernel_bank_loader.sv - streams up to NUM_CH kernels from weight BRAM into kernel register banks
// Purpose : on one start, reads popcount(mask)*elem weights (channel ascending, element
//           ascending) and writes each into bank c at address e BRAM_RD_LAT cycles later.
// Ports   : i_clk, i_rst                  clock, synchronous active-high reset
//           i_start                       start request, sampled in IDLE only
//           i_ch_mask                     channels to load (bit c = bank c)
//           i_elem_count                  elements per kernel, 1..2**KREG_ADDR_WIDTH
//           i_base_addr, i_ch_stride      channel-0 base address, distance between channels
//           o_bram_rd_en, o_bram_addr     BRAM read strobe and address
//           i_bram_data                   BRAM data, BRAM_RD_LAT cycles after the address
//           o_wr_en, o_kreg_addr, o_kreg_data  one-hot bank write port
//           o_busy, o_done, o_err         status; o_err pulses with o_done on a bad request
module kernel_bank_loader
   import kernel_bank_loader_pkg::*;
#(
   parameter int WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
   parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH,
   parameter int KREG_ADDR_WIDTH = DEF_KREG_ADDR_WIDTH,
   parameter int NUM_CH          = DEF_NUM_CH,
   parameter int BRAM_RD_LAT     = DEF_BRAM_RD_LAT
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [NUM_CH-1:0]          i_ch_mask,
   input  logic [KREG_ADDR_WIDTH:0]   i_elem_count,
   input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
   input  logic [BRAM_ADDR_WIDTH-1:0] i_ch_stride,
   output logic                       o_bram_rd_en,
   output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
   input  logic [WEIGHT_WIDTH-1:0]    i_bram_data,
   output logic [NUM_CH-1:0]          o_wr_en,
   output logic [KREG_ADDR_WIDTH-1:0] o_kreg_addr,
   output logic [WEIGHT_WIDTH-1:0]    o_kreg_data,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ELEM_W = KREG_ADDR_WIDTH + 1;
   localparam int LAT_W  = $clog2(BRAM_RD_LAT + 1);
   localparam logic [ELEM_W-1:0] MAX_ELEM = ELEM_W'(2 ** KREG_ADDR_WIDTH);

   state_t state_q, state_d;

   logic [NUM_CH-1:0]          mask_q;
   logic [ELEM_W-1:0]          elem_q;
   logic [BRAM_ADDR_WIDTH-1:0] base_q;
   logic [BRAM_ADDR_WIDTH-1:0] stride_q;
   logic                       err_q;
   logic [CH_W-1:0]            ch_q;
   logic [KREG_ADDR_WIDTH-1:0] el_q;
   logic [LAT_W-1:0]           lat_q;

   logic                       illegal;
   logic [CH_W-1:0]            first_ch;
   logic [CH_W-1:0]            next_ch;
   logic                       next_found;
   logic                       last_elem;
   logic [BRAM_ADDR_WIDTH-1:0] rd_addr;

   logic                       pipe_valid;
   logic [CH_W-1:0]            pipe_ch;
   logic [KREG_ADDR_WIDTH-1:0] pipe_elem;

   assign illegal = (i_ch_mask == '0) || (i_elem_count == '0) || (i_elem_count > MAX_ELEM);

   // Lowest set bit of the incoming mask: the first channel to load.
   always_comb begin
      first_ch = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (i_ch_mask[c]) first_ch = CH_W'(c);
      end
   end

   // Lowest enabled channel strictly above the current one; masked-off channels are skipped.
   always_comb begin
      next_ch    = '0;
      next_found = 1'b0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (mask_q[c] && (c > int'(ch_q))) begin
            next_ch    = CH_W'(c);
            next_found = 1'b1;
         end
      end
   end

   assign last_elem = (ELEM_W'(el_q) == (elem_q - ELEM_W'(1)));

   // Address arithmetic wraps modulo 2**BRAM_ADDR_WIDTH by truncation.
   assign rd_addr = base_q + (stride_q * BRAM_ADDR_WIDTH'(ch_q)) + BRAM_ADDR_WIDTH'(el_q);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      o_busy       = 1'b0;
      o_bram_rd_en = 1'b0;
      o_bram_addr  = '0;
      o_done       = 1'b0;
      o_err        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) state_d = illegal ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            o_busy       = 1'b1;
            o_bram_rd_en = 1'b1;
            o_bram_addr  = rd_addr;
            if (last_elem && !next_found) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            o_busy = 1'b1;
            if (lat_q == LAT_W'(BRAM_RD_LAT - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            o_done  = 1'b1;
            o_err   = err_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Config latch and channel/element/drain counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mask_q   <= '0;
         elem_q   <= '0;
         base_q   <= '0;
         stride_q <= '0;
         err_q    <= 1'b0;
         ch_q     <= '0;
         el_q     <= '0;
         lat_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  mask_q   <= i_ch_mask;
                  elem_q   <= i_elem_count;
                  base_q   <= i_base_addr;
                  stride_q <= i_ch_stride;
                  err_q    <= illegal;
                  ch_q     <= first_ch;
                  el_q     <= '0;
               end
            end
            ST_ISSUE: begin
               lat_q <= '0;
               if (last_elem) begin
                  el_q <= '0;
                  if (next_found) ch_q <= next_ch;
               end else begin
                  el_q <= el_q + KREG_ADDR_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               lat_q <= lat_q + LAT_W'(1);
            end
            default: ;
         endcase
      end
   end

   rd_lat_pipe #(
      .DEPTH  (BRAM_RD_LAT),
      .CH_W   (CH_W),
      .ELEM_W (KREG_ADDR_WIDTH)
   ) u_rd_lat_pipe (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (o_bram_rd_en),
      .i_ch    (ch_q),
      .i_elem  (el_q),
      .o_valid (pipe_valid),
      .o_ch    (pipe_ch),
      .o_elem  (pipe_elem)
   );

   always_comb begin
      o_wr_en     = '0;
      o_kreg_addr = '0;
      o_kreg_data = '0;
      if (pipe_valid) begin
         o_wr_en     = NUM_CH'(1) << pipe_ch;
         o_kreg_addr = pipe_elem;
         o_kreg_data = i_bram_data;
      end
   end

endmodule

// File: tb/tb_kernel_bank_loader.sv
// tb/tb_kernel_bank_loader.sv - directed table-driven bench for kernel_bank_loader
module tb_kernel_bank_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] mask;
   logic [6:0] elem;
   logic [9:0] base;
   logic [9:0] stride;

   logic       d1_rd, d2_rd;
   logic [9:0] d1_addr, d2_addr;
   logic [7:0] d1_bdata, d2_bdata, d2_bpipe;
   logic [3:0] d1_wr, d2_wr;
   logic [5:0] d1_kaddr, d2_kaddr;
   logic [7:0] d1_kdata, d2_kdata;
   logic       d1_busy, d2_busy, d1_done, d2_done, d1_err, d2_err;

   logic [7:0] mem [1024];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   kernel_bank_loader #(.BRAM_RD_LAT(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_ch_mask(mask), .i_elem_count(elem),
      .i_base_addr(base), .i_ch_stride(stride), .o_bram_rd_en(d1_rd), .o_bram_addr(d1_addr),
      .i_bram_data(d1_bdata), .o_wr_en(d1_wr), .o_kreg_addr(d1_kaddr), .o_kreg_data(d1_kdata),
      .o_busy(d1_busy), .o_done(d1_done), .o_err(d1_err)
   );

   kernel_bank_loader #(.BRAM_RD_LAT(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_ch_mask(mask), .i_elem_count(elem),
      .i_base_addr(base), .i_ch_stride(stride), .o_bram_rd_en(d2_rd), .o_bram_addr(d2_addr),
      .i_bram_data(d2_bdata), .o_wr_en(d2_wr), .o_kreg_addr(d2_kaddr), .o_kreg_data(d2_kdata),
      .o_busy(d2_busy), .o_done(d2_done), .o_err(d2_err)
   );

   // BRAM models with one and two cycles of read latency.
   always @(posedge clk) begin
      if (d1_rd) d1_bdata <= mem[d1_addr];
      if (d2_rd) d2_bpipe <= mem[d2_addr];
      d2_bdata <= d2_bpipe;
   end

   typedef struct {
      logic [3:0] mask;
      logic [6:0] elem;
      logic [9:0] base;
      logic [9:0] stride;
      bit         sel;       // 0: latency-1 instance, 1: latency-2 instance
      int         t;         // expected number of reads
      bit         err;
      int         done_cyc;
   } vec_t;

   vec_t tbl [9];

   int exp_ch [256];
   int exp_e  [256];
   int exp_a  [256];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs_or(input bit sel);
      if (sel)
         return int'(d2_rd) | int'(d2_addr) | int'(d2_wr) | int'(d2_kaddr) | int'(d2_kdata)
              | int'(d2_busy) | int'(d2_done) | int'(d2_err);
      return int'(d1_rd) | int'(d1_addr) | int'(d1_wr) | int'(d1_kaddr) | int'(d1_kdata)
           | int'(d1_busy) | int'(d1_done) | int'(d1_err);
   endfunction

   task automatic run_case(input int idx, input vec_t v);
      int n, lat, w;
      int done_cyc, n_done, n_err, n_rd, n_wr;
      int bad_rd, bad_addr, bad_wr, bad_busy, idle_bad;
      logic       rd, busy, done, err;
      logic [9:0] addr;
      logic [3:0] wr;
      logic [5:0] kaddr;
      logic [7:0] kdata;
      bit exp_rd, exp_wr, exp_busy;

      n = 0;
      if (!v.err) begin
         for (int c = 0; c < 4; c++) begin
            if (v.mask[c]) begin
               for (int e = 0; e < int'(v.elem); e++) begin
                  exp_ch[n] = c;
                  exp_e[n]  = e;
                  exp_a[n]  = (int'(v.base) + c * int'(v.stride) + e) % 1024;
                  n++;
               end
            end
         end
      end
      lat = v.sel ? 2 : 1;
      done_cyc = 0; n_done = 0; n_err = 0; n_rd = 0; n_wr = 0;
      bad_rd = 0; bad_addr = 0; bad_wr = 0; bad_busy = 0; idle_bad = 0;

      @(negedge clk);
      mask = v.mask; elem = v.elem; base = v.base; stride = v.stride; start = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= v.t + lat + 3; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         if (cyc == 2) begin
            base = 10'h3a5; stride = 10'd1; mask = 4'hf; elem = 7'd3;
         end
         rd    = v.sel ? d2_rd    : d1_rd;
         addr  = v.sel ? d2_addr  : d1_addr;
         wr    = v.sel ? d2_wr    : d1_wr;
         kaddr = v.sel ? d2_kaddr : d1_kaddr;
         kdata = v.sel ? d2_kdata : d1_kdata;
         busy  = v.sel ? d2_busy  : d1_busy;
         done  = v.sel ? d2_done  : d1_done;
         err   = v.sel ? d2_err   : d1_err;

         exp_rd = (cyc <= v.t);
         n_rd += int'(rd);
         if (rd != exp_rd) bad_rd++;
         else if (rd && int'(addr) != exp_a[cyc-1]) bad_addr++;
         if (!rd && addr != 10'd0) idle_bad++;

         exp_wr = (cyc > lat) && (cyc <= v.t + lat);
         if ((wr != 4'd0) != exp_wr) bad_wr++;
         else if (exp_wr) begin
            w = cyc - 1 - lat;
            n_wr++;
            if (int'(wr) != (1 << exp_ch[w]) || int'(kaddr) != exp_e[w] || kdata != mem[exp_a[w]])
               bad_wr++;
         end
         if (!exp_wr && (kaddr != 6'd0 || kdata != 8'd0)) idle_bad++;

         exp_busy = !v.err && (cyc <= v.t + lat);
         if (busy != exp_busy) bad_busy++;
         if (done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (err) begin
            n_err++;
            if (!done) idle_bad++;
         end
      end

      chk($sformatf("case%0d_done_cycle", idx), done_cyc, v.done_cyc);
      chk($sformatf("case%0d_done_pulses", idx), n_done, 1);
      chk($sformatf("case%0d_err_pulses", idx), n_err, int'(v.err));
      chk($sformatf("case%0d_reads", idx), n_rd, v.t);
      chk($sformatf("case%0d_writes", idx), n_wr, v.t);
      chk($sformatf("case%0d_rd_timing", idx), bad_rd, 0);
      chk($sformatf("case%0d_rd_addr", idx), bad_addr, 0);
      chk($sformatf("case%0d_wr_content", idx), bad_wr, 0);
      chk($sformatf("case%0d_busy", idx), bad_busy, 0);
      chk($sformatf("case%0d_idle_zero", idx), idle_bad, 0);
   endtask

   initial begin
      int dones;

      for (int a = 0; a < 1024; a++) mem[a] = 8'(a * 37 + 11);
      d1_bdata = '0; d2_bdata = '0; d2_bpipe = '0;

      //               mask     elem   base     stride  sel  T    err  done
      tbl[0] = '{4'b0001, 7'd9,  10'd0,    10'd0,   1'b0, 9,   1'b0, 11};
      tbl[1] = '{4'b1010, 7'd9,  10'd100,  10'd9,   1'b0, 18,  1'b0, 20};
      tbl[2] = '{4'b1111, 7'd64, 10'd0,    10'd64,  1'b1, 256, 1'b0, 259};
      tbl[3] = '{4'b0001, 7'd0,  10'd0,    10'd0,   1'b0, 0,   1'b1, 1};
      tbl[4] = '{4'b0000, 7'd9,  10'd0,    10'd0,   1'b0, 0,   1'b1, 1};
      tbl[5] = '{4'b0001, 7'd9,  10'd1020, 10'd0,   1'b0, 9,   1'b0, 11};
      tbl[6] = '{4'b0001, 7'd65, 10'd0,    10'd0,   1'b1, 0,   1'b1, 1};
      tbl[7] = '{4'b1000, 7'd64, 10'd500,  10'd3,   1'b0, 64,  1'b0, 66};
      tbl[8] = '{4'b0101, 7'd1,  10'd7,    10'd200, 1'b1, 2,   1'b0, 5};

      rst = 1'b1; start = 1'b0; mask = '0; elem = '0; base = '0; stride = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs_lat1", outs_or(1'b0), 0);
      chk("reset_outs_lat2", outs_or(1'b1), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_case(i, tbl[i]);

      // Start pulses while busy are ignored; reset mid-transfer aborts without a done.
      @(negedge clk);
      mask = 4'b0001; elem = 7'd9; base = 10'd0; stride = 10'd0; start = 1'b1;
      @(posedge clk);
      dones = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         case (cyc)
            1: start = 1'b0;
            3: begin start = 1'b1; base = 10'd500; end
            4: begin
               start = 1'b0;
               chk("ignored_start_addr", int'(d1_addr), 3);
               chk("ignored_start_busy", int'(d1_busy), 1);
            end
            5: begin start = 1'b1; rst = 1'b1; end
            6: begin
               chk("midrst_outs_lat1", outs_or(1'b0), 0);
               chk("midrst_outs_lat2", outs_or(1'b1), 0);
               start = 1'b0; rst = 1'b0;
            end
            default: ;
         endcase
         if (cyc >= 6) dones += int'(d1_done) + int'(d2_done);
      end
      chk("midrst_no_done", dones, 0);

      run_case(9, tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
